// File: rtl/pll_ce_pkg.sv
// Shared state encoding and default parameters for the PLL lock / clock-enable controller.
package pll_ce_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_FILTER    = 3'd2,
        ST_RUN       = 3'd3,
        ST_PLL_RST   = 3'd4,
        ST_FAULT     = 3'd5
    } state_e;

    localparam int unsigned NUM_CE_DEF     = 4;
    localparam int unsigned DIV_W_DEF      = 16;
    localparam int unsigned LOCK_FILT_DEF  = 1024;
    localparam int unsigned LOCK_TMO_DEF   = 65536;
    localparam int unsigned RST_PULSE_DEF  = 16;
    localparam int unsigned RELOCK_MAX_DEF = 3;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pll_ce_ctrl_ce_div.sv
// Single-channel clock-enable divider with a shadow ratio adopted only at period boundaries.
module ce_div #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             run_d,
    input  logic [DIV_W-1:0] div_cfg,
    input  logic             div_load,
    output logic             ce
);

    logic [DIV_W-1:0] shadow_q;
    logic [DIV_W-1:0] active_q;
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] src;
    logic [DIV_W-1:0] shadow_d;
    logic [DIV_W-1:0] act_d;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] term;
    logic             adopt;
    logic             ce_d;

    // A load landing on the ce cycle bypasses the shadow so the new ratio starts next period.
    always_comb begin
        src      = div_load ? div_cfg : shadow_q;
        shadow_d = src;
        adopt    = !run || !run_d || ce;
        act_d    = adopt ? src : active_q;
        cnt_d    = adopt ? '0 : cnt_q + DIV_W'(1);
        term     = (act_d <= DIV_W'(1)) ? '0 : act_d - DIV_W'(1);
        ce_d     = run_d && (cnt_d == term);
        if (!run_d) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= DIV_W'(1);
            active_q <= DIV_W'(1);
            cnt_q    <= '0;
            ce       <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= act_d;
            cnt_q    <= cnt_d;
            ce       <= ce_d;
        end
    end

endmodule

// File: rtl/pll_ce_ctrl.sv
// PLL lock supervisor: filters lock, issues PLL resets on timeout/loss, gates system reset and clock enables.
module pll_ce_ctrl
    import pll_ce_pkg::*;
#(
    parameter int unsigned NUM_CE     = NUM_CE_DEF,
    parameter int unsigned DIV_W      = DIV_W_DEF,
    parameter int unsigned LOCK_FILT  = LOCK_FILT_DEF,
    parameter int unsigned LOCK_TMO   = LOCK_TMO_DEF,
    parameter int unsigned RST_PULSE  = RST_PULSE_DEF,
    parameter int unsigned RELOCK_MAX = RELOCK_MAX_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    lock,
    output logic                    pll_reset,
    input  logic [NUM_CE*DIV_W-1:0] div_cfg,
    input  logic                    div_load,
    output logic [NUM_CE-1:0]       ce,
    output logic                    sys_rst_n,
    output logic [2:0]              state,
    output logic [7:0]              relock_cnt,
    output logic                    fault
);

    localparam int unsigned CNT_MAX = max_u(max_u(LOCK_TMO, LOCK_FILT), RST_PULSE);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    logic             lock_m;
    logic             lock_s;
    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [7:0]       relock_q;
    logic [7:0]       relock_d;
    logic             run;
    logic             run_d;

    // Two-flop synchronizer for the asynchronous lock flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= lock;
            lock_s <= lock_m;
        end
    end

    // One shared counter serves as lock timeout, lock filter and reset pulse timer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        relock_d = relock_q;
        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_WAIT_LOCK;
                cnt_d   = '0;
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = ST_FILTER;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(LOCK_TMO - 1)) begin
                    state_d = ST_PLL_RST;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_FILTER: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(LOCK_FILT - 1)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_d = ST_PLL_RST;
                    cnt_d   = '0;
                end
            end
            ST_PLL_RST: begin
                if (cnt_q == CNT_W'(RST_PULSE - 1)) begin
                    cnt_d    = '0;
                    relock_d = (relock_q == 8'hFF) ? relock_q : relock_q + 8'd1;
                    state_d  = (relock_d == 8'(RELOCK_MAX)) ? ST_FAULT : ST_WAIT_LOCK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the same edge as state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            relock_q  <= '0;
            pll_reset <= 1'b0;
            sys_rst_n <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            relock_q  <= relock_d;
            pll_reset <= (state_d == ST_PLL_RST) || (state_d == ST_FAULT);
            sys_rst_n <= (state_d == ST_RUN);
            fault     <= (state_d == ST_FAULT);
        end
    end

    assign state      = state_q;
    assign relock_cnt = relock_q;
    assign run        = (state_q == ST_RUN);
    assign run_d      = (state_d == ST_RUN);

    for (genvar i = 0; i < NUM_CE; i++) begin : g_ce
        ce_div #(
            .DIV_W(DIV_W)
        ) u_ce_div (
            .clk     (clk),
            .rst_n   (rst_n),
            .run     (run),
            .run_d   (run_d),
            .div_cfg (div_cfg[i*DIV_W +: DIV_W]),
            .div_load(div_load),
            .ce      (ce[i])
        );
    end

endmodule

// File: tb/tb_pll_ce_ctrl.sv
// Directed bench for pll_ce_ctrl: vector table for lock/relock flow plus hand sequences for corners.
module tb_pll_ce_ctrl;
    import pll_ce_pkg::*;

    localparam int unsigned NUM_CE = 2;
    localparam int unsigned DIV_W  = 16;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    lock = 1'b0;
    logic                    div_load = 1'b0;
    logic [NUM_CE*DIV_W-1:0] div_cfg = '0;
    logic                    pll_reset;
    logic [NUM_CE-1:0]       ce;
    logic                    sys_rst_n;
    logic [2:0]              state;
    logic [7:0]              relock_cnt;
    logic                    fault;

    int errors = 0;
    int checks = 0;
    int n, wait_cnt, prst_cnt, first_rise;
    bit seen;

    typedef struct {
        string      name;
        logic       lock;
        int         cycles;
        logic [2:0] st;
        logic       srst;
        logic       prst;
        logic       ce_chk;
        logic [1:0] ce_exp;
        logic [7:0] rel;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    pll_ce_ctrl #(
        .NUM_CE    (NUM_CE),
        .DIV_W     (DIV_W),
        .LOCK_FILT (8),
        .LOCK_TMO  (64),
        .RST_PULSE (4),
        .RELOCK_MAX(3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .lock      (lock),
        .pll_reset (pll_reset),
        .div_cfg   (div_cfg),
        .div_load  (div_load),
        .ce        (ce),
        .sys_rst_n (sys_rst_n),
        .state     (state),
        .relock_cnt(relock_cnt),
        .fault     (fault)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add_vec(input string nm, input logic lk, input int cyc, input logic [2:0] st,
                           input logic srst, input logic prst, input logic cchk,
                           input logic [1:0] cexp, input logic [7:0] rel);
        vec_t v;
        v.name = nm; v.lock = lk; v.cycles = cyc; v.st = st; v.srst = srst;
        v.prst = prst; v.ce_chk = cchk; v.ce_exp = cexp; v.rel = rel;
        vecs.push_back(v);
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            lock = vecs[i].lock;
            repeat (vecs[i].cycles) step();
            chk({vecs[i].name, "_state"}, 32'(state), 32'(vecs[i].st));
            chk({vecs[i].name, "_sys_rst_n"}, 32'(sys_rst_n), 32'(vecs[i].srst));
            chk({vecs[i].name, "_pll_reset"}, 32'(pll_reset), 32'(vecs[i].prst));
            chk({vecs[i].name, "_relock"}, 32'(relock_cnt), 32'(vecs[i].rel));
            if (vecs[i].ce_chk) chk({vecs[i].name, "_ce"}, 32'(ce), 32'(vecs[i].ce_exp));
        end
    endtask

    // Steps until ce[1] pulses; n counts steps since the last pulse starting from 'start'.
    task automatic gap_ce1(input string name, input int start, input int exp);
        int k;
        k = start;
        do begin
            step();
            k++;
        end while (ce[1] !== 1'b1 && k < 40);
        chk(name, 32'(k), 32'(exp));
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        lock = 1'b0;
        div_load = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    initial begin
        // Lock acquisition: lock rises, FILTER runs 8 cycles after two sync cycles.
        add_vec("wait_idle",   1'b0, 8, ST_WAIT_LOCK, 1'b0, 1'b0, 1'b1, 2'b00, 8'd0);
        add_vec("sync_filter", 1'b1, 9, ST_FILTER,    1'b0, 1'b0, 1'b1, 2'b00, 8'd0);
        add_vec("filter_last", 1'b1, 1, ST_FILTER,    1'b0, 1'b0, 1'b1, 2'b00, 8'd0);
        add_vec("run_entry",   1'b1, 1, ST_RUN,       1'b1, 1'b0, 1'b1, 2'b00, 8'd0);
        // One-cycle lock loss in RUN, reset pulse, then relock.
        add_vec("drop_sample", 1'b0, 1, ST_RUN,       1'b1, 1'b0, 1'b0, 2'b00, 8'd0);
        add_vec("drop_sync",   1'b1, 1, ST_RUN,       1'b1, 1'b0, 1'b0, 2'b00, 8'd0);
        add_vec("drop_exit",   1'b1, 1, ST_PLL_RST,   1'b0, 1'b1, 1'b1, 2'b00, 8'd0);
        add_vec("pulse_hold",  1'b1, 3, ST_PLL_RST,   1'b0, 1'b1, 1'b1, 2'b00, 8'd0);
        add_vec("pulse_end",   1'b1, 1, ST_WAIT_LOCK, 1'b0, 1'b0, 1'b1, 2'b00, 8'd1);
        add_vec("relock_filt", 1'b1, 1, ST_FILTER,    1'b0, 1'b0, 1'b1, 2'b00, 8'd1);
        add_vec("relock_hold", 1'b1, 7, ST_FILTER,    1'b0, 1'b0, 1'b1, 2'b00, 8'd1);
        add_vec("relock_run",  1'b1, 1, ST_RUN,       1'b1, 1'b0, 1'b1, 2'b00, 8'd1);

        div_cfg = {16'd4, 16'd5};
        repeat (2) step();
        chk("reset_state", 32'(state), 32'(ST_IDLE));
        chk("reset_pll_reset", 32'(pll_reset), 32'd0);
        chk("reset_sys_rst_n", 32'(sys_rst_n), 32'd0);
        chk("reset_ce", 32'(ce), 32'd0);
        chk("reset_fault", 32'(fault), 32'd0);
        chk("reset_relock", 32'(relock_cnt), 32'd0);

        rst_n = 1'b1;
        step();
        chk("idle_to_wait", 32'(state), 32'(ST_WAIT_LOCK));
        div_load = 1'b1;
        step();
        div_load = 1'b0;

        run_vecs(0, 3);
        // First RUN cycle is index 0: div 5 pulses at 4,9,..., div 4 at 3,7,...
        for (int idx = 1; idx < 20; idx++) begin
            step();
            chk($sformatf("ce0_idx%0d", idx), 32'(ce[0]), 32'((idx % 5) == 4));
            chk($sformatf("ce1_idx%0d", idx), 32'(ce[1]), 32'((idx % 4) == 3));
        end
        run_vecs(4, 11);

        // Ratio change mid-period: current period of 4 completes, then 7.
        n = 0;
        while (ce[1] !== 1'b1 && n < 20) begin step(); n++; end
        chk("ce1_found", 32'(ce[1]), 32'd1);
        step();
        div_cfg[31:16] = 16'd7;
        div_load = 1'b1;
        step();
        div_load = 1'b0;
        gap_ce1("gap_old_ratio", 2, 4);
        gap_ce1("gap_new_ratio", 0, 7);
        gap_ce1("gap_new_ratio2", 0, 7);
        // Load on the pulse cycle: that pulse used the old ratio, next period uses 3.
        div_cfg[31:16] = 16'd3;
        div_load = 1'b1;
        step();
        div_load = 1'b0;
        chk("coincide_no_pulse", 32'(ce[1]), 32'd0);
        gap_ce1("gap_coincide", 1, 3);
        gap_ce1("gap_coincide2", 0, 3);
        // Ratio 0 behaves as divide-by-1.
        div_cfg[31:16] = 16'd0;
        div_load = 1'b1;
        step();
        div_load = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("div0_ce1_k%0d", k), 32'(ce[1]), 32'd1);
            step();
        end

        // Async reset in the middle of a PLL reset pulse with relock_cnt already 1.
        lock = 1'b0;
        n = 0;
        while (pll_reset !== 1'b1 && n < 10) begin step(); n++; end
        chk("pulse_before_rst", 32'(pll_reset), 32'd1);
        step();
        chk("relock_before_rst", 32'(relock_cnt), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_state", 32'(state), 32'(ST_IDLE));
        chk("async_pll_reset", 32'(pll_reset), 32'd0);
        chk("async_sys_rst_n", 32'(sys_rst_n), 32'd0);
        chk("async_ce", 32'(ce), 32'd0);
        chk("async_fault", 32'(fault), 32'd0);
        chk("async_relock", 32'(relock_cnt), 32'd0);

        // Lock glitch during FILTER: 5 high, 1 low, high again restarts the filter.
        apply_reset();
        step();
        lock = 1'b1;
        repeat (5) step();
        lock = 1'b0;
        step();
        lock = 1'b1;
        n = 0;
        seen = 1'b0;
        do begin
            step();
            n++;
            if (n == 2) chk("glitch_back_to_wait", 32'(state), 32'(ST_WAIT_LOCK));
            if (n == 4) chk("glitch_not_run_early", 32'(state), 32'(ST_FILTER));
        end while (state != ST_RUN && n < 30);
        // Two sync cycles, one WAIT_LOCK cycle, eight filter cycles.
        chk("glitch_run_latency", 32'(n), 32'd11);

        // Lock never rises: three timeouts then FAULT.
        apply_reset();
        n = 0; wait_cnt = 0; prst_cnt = 0; first_rise = 0;
        while (fault !== 1'b1 && n < 400) begin
            step();
            n++;
            if (state == ST_WAIT_LOCK) wait_cnt++;
            if (pll_reset && !fault) begin
                prst_cnt++;
                if (first_rise == 0) first_rise = n;
            end
        end
        chk("tmo_first_rise", 32'(first_rise), 32'd65);
        chk("tmo_wait_cycles", 32'(wait_cnt), 32'd192);
        chk("tmo_pulse_cycles", 32'(prst_cnt), 32'd12);
        chk("fault_flag", 32'(fault), 32'd1);
        chk("fault_relock", 32'(relock_cnt), 32'd3);
        lock = 1'b1;
        repeat (10) step();
        chk("fault_hold_state", 32'(state), 32'(ST_FAULT));
        chk("fault_hold_pll_reset", 32'(pll_reset), 32'd1);
        chk("fault_hold_sys_rst_n", 32'(sys_rst_n), 32'd0);
        chk("fault_hold_ce", 32'(ce), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
